// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//   Register busy-bit scoreboard for an in-order issue pipeline. Each
//   architectural register index has one busy bit. An issuing instruction marks
//   its destination busy, and writeback clears it. Source operands are checked
//   against the busy vector. Writeback bypass lets a source or destination that
//   is written back in the current cycle count as ready.
//
// Parameters
//   ADDR_W   register-index width; NUM = 2**ADDR_W entries
//   ZERO_REG when 1, index 0 is hard-wired not-busy (RISC-style x0)
//
// Ports
//   clk        clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   iss_en     issue request for destination iss_addr
//   iss_addr   destination index of the issuing instruction
//   wb_en      writeback strobe for wb_addr
//   wb_addr    writeback destination index
//   flush      synchronous clear of all busy bits
//   rs1_addr   first source index to check
//   rs2_addr   second source index to check
//   iss_ready  combinational: an issue to iss_addr can be accepted this cycle
//   rs1_busy   combinational: source 1 not yet written
//   rs2_busy   combinational: source 2 not yet written
//   busy       registered busy vector, busy[i] belongs to index i
//   busy_cnt   registered population count of busy
//   wb_err     registered, sticky: writeback to a non-busy entry was seen
// -----------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          rs1_addr,
  input  logic [ADDR_W-1:0]          rs2_addr,
  output logic                       iss_ready,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic [ADDR_W:0]            busy_cnt,
  output logic                       wb_err
);

  localparam int NUM = 1 << ADDR_W;

  // Entries that can never become busy (only index 0, and only with ZERO_REG).
  localparam logic [NUM-1:0] ZERO_MASK = (ZERO_REG != 0) ? NUM'(1) : '0;

  logic [NUM-1:0] iss_oh;
  logic [NUM-1:0] wb_oh;
  logic [NUM-1:0] busy_next;
  logic [ADDR_W:0] cnt_next;
  logic           iss_accept;
  logic           wb_bad;

  // A writeback "hits" an index when it targets it this cycle.
  function automatic logic wb_hit(input logic [ADDR_W-1:0] idx);
    return wb_en && (wb_addr == idx);
  endfunction

  // Index 0 is reported as never busy when it is hard-wired.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Enable-gated one-hot decodes of the issue and writeback indices.
  always_comb begin
    iss_oh = '0;
    wb_oh  = '0;
    if (iss_en) iss_oh[iss_addr] = 1'b1;
    if (wb_en)  wb_oh[wb_addr]   = 1'b1;
  end

  // Readiness and source checks, with writeback bypass so a register being
  // written this cycle is already considered available.
  always_comb begin
    iss_ready = ~busy[iss_addr] | wb_hit(iss_addr) | is_zero_reg(iss_addr);
    rs1_busy  = busy[rs1_addr] & ~wb_hit(rs1_addr) & ~is_zero_reg(rs1_addr);
    rs2_busy  = busy[rs2_addr] & ~wb_hit(rs2_addr) & ~is_zero_reg(rs2_addr);
  end

  // Next busy vector: the clear is applied before the set so that an issue and
  // a writeback to the same index leave the bit set. Flush overrides both.
  // A writeback to an idle entry is flagged even during a flush.
  always_comb begin
    iss_accept = iss_en & iss_ready & ~flush;
    wb_bad     = wb_en & ~busy[wb_addr] & ~is_zero_reg(wb_addr);
    if (flush) begin
      busy_next = '0;
    end else begin
      busy_next = ((busy & ~wb_oh) | (iss_accept ? iss_oh : '0)) & ~ZERO_MASK;
    end
    cnt_next = '0;
    for (int i = 0; i < NUM; i++) begin
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end
  end

  // State registers; the count is computed from the next vector so it lands on
  // the same edge as the busy bits it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      if (wb_bad) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//   Directed testbench for reg_scoreboard with default parameters
//   (ADDR_W=3, ZERO_REG=1). Inputs change 1 time unit after a rising edge.
//   Outputs are sampled either in the middle of a cycle (combinational) or
//   1 time unit after the edge (registered).
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       iss_en;
  logic [2:0] iss_addr;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic       flush;
  logic [2:0] rs1_addr;
  logic [2:0] rs2_addr;
  logic       iss_ready;
  logic       rs1_busy;
  logic       rs2_busy;
  logic [7:0] busy;
  logic [3:0] busy_cnt;
  logic       wb_err;

  int vectors;
  int miscompares;

  reg_scoreboard #(.ADDR_W(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .iss_ready(iss_ready), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy(busy), .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return all request inputs to idle.
  task automatic idle_inputs();
    iss_en = 1'b0; iss_addr = '0; wb_en = 1'b0; wb_addr = '0;
    flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    vectors++; if (busy !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_busy: got %h expected %h", busy, 8'h00); end
    vectors++; if (busy_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d expected %0d", busy_cnt, 0); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wb_err: got %b expected %b", wb_err, 1'b0); end
    tick();
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_iss_ready: got %b expected %b", iss_ready, 1'b1); end
    vectors++; if ({rs1_busy, rs2_busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_rs_busy: got %b expected %b", {rs1_busy, rs2_busy}, 2'b00); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Issue to 3, then a second issue to 3 must stall without changing state.
  task automatic test_issue_hold();
    iss_en = 1'b1; iss_addr = 3'd3;
    #1;
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL issue3_ready: got %b expected %b", iss_ready, 1'b1); end
    tick();
    iss_en = 1'b0; rs1_addr = 3'd3;
    #1;
    vectors++; if (busy !== 8'b0000_1000) begin miscompares++; $display("[TB] FAIL issue3_busy: got %b expected %b", busy, 8'b0000_1000); end
    vectors++; if (busy_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL issue3_cnt: got %0d expected %0d", busy_cnt, 1); end
    vectors++; if (rs1_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL issue3_rs1_busy: got %b expected %b", rs1_busy, 1'b1); end
    iss_en = 1'b1; iss_addr = 3'd3;
    #1;
    vectors++; if (iss_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall3_ready: got %b expected %b", iss_ready, 1'b0); end
    tick();
    vectors++; if (busy !== 8'h08 || busy_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL stall3_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'h08, 1); end
    idle_inputs();
  endtask

  // Issue and writeback to the same busy index: set wins, count unchanged.
  task automatic test_same_index();
    iss_en = 1'b1; iss_addr = 3'd5;
    tick();
    vectors++; if (busy !== 8'h28 || busy_cnt !== 4'd2) begin miscompares++; $display("[TB] FAIL issue5_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'h28, 2); end
    wb_en = 1'b1; wb_addr = 3'd5;
    #1;
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL same5_ready: got %b expected %b", iss_ready, 1'b1); end
    tick();
    vectors++; if (busy !== 8'h28 || busy_cnt !== 4'd2) begin miscompares++; $display("[TB] FAIL same5_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'h28, 2); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL same5_wb_err: got %b expected %b", wb_err, 1'b0); end
    idle_inputs();
  endtask

  // Writeback bypass on rs2, then issue and writeback to different indices.
  task automatic test_bypass();
    iss_en = 1'b1; iss_addr = 3'd2;
    tick();
    iss_en = 1'b0; rs2_addr = 3'd2;
    #1;
    vectors++; if (rs2_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rs2_busy_nowb: got %b expected %b", rs2_busy, 1'b1); end
    wb_en = 1'b1; wb_addr = 3'd2;
    #1;
    vectors++; if (rs2_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rs2_bypass: got %b expected %b", rs2_busy, 1'b0); end
    tick();
    vectors++; if (busy !== 8'h28 || busy_cnt !== 4'd2) begin miscompares++; $display("[TB] FAIL wb2_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'h28, 2); end
    wb_en = 1'b1; wb_addr = 3'd3; iss_en = 1'b1; iss_addr = 3'd7;
    tick();
    vectors++; if (busy !== 8'hA0 || busy_cnt !== 4'd2) begin miscompares++; $display("[TB] FAIL diff_idx_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'hA0, 2); end
    idle_inputs();
  endtask

  // Index 0 never becomes busy; writeback to an idle index sets sticky wb_err.
  task automatic test_zero_reg();
    iss_en = 1'b1; iss_addr = 3'd0; rs1_addr = 3'd0;
    #1;
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_ready: got %b expected %b", iss_ready, 1'b1); end
    tick();
    vectors++; if (busy !== 8'hA0 || rs1_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_issue: got %h/%b expected %h/%b", busy, rs1_busy, 8'hA0, 1'b0); end
    iss_en = 1'b0; wb_en = 1'b1; wb_addr = 3'd0;
    tick();
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_wb_err: got %b expected %b", wb_err, 1'b0); end
    wb_addr = 3'd6;
    tick();
    vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("[TB] FAIL wb6_err: got %b expected %b", wb_err, 1'b1); end
    vectors++; if (busy !== 8'hA0 || busy_cnt !== 4'd2) begin miscompares++; $display("[TB] FAIL wb6_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'hA0, 2); end
    idle_inputs();
    tick();
    tick();
    vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_err_sticky: got %b expected %b", wb_err, 1'b1); end
  endtask

  // Fill 1..7 from empty, then flush with a competing issue.
  task automatic test_flush();
    rst_n = 1'b0;
    #2;
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_pre_reset_err: got %b expected %b", wb_err, 1'b0); end
    rst_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      iss_en = 1'b1; iss_addr = 3'(i);
      tick();
    end
    vectors++; if (busy !== 8'hFE || busy_cnt !== 4'd7) begin miscompares++; $display("[TB] FAIL fill_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'hFE, 7); end
    iss_addr = 3'd4; flush = 1'b1;
    tick();
    vectors++; if (busy !== 8'h00 || busy_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL flush_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'h00, 0); end
    iss_en = 1'b0; wb_en = 1'b1; wb_addr = 3'd3;
    tick();
    vectors++; if (wb_err !== 1'b1 || busy !== 8'h00) begin miscompares++; $display("[TB] FAIL flush_wb_err: got %b/%h expected %b/%h", wb_err, busy, 1'b1, 8'h00); end
    idle_inputs();
  endtask

  // Asynchronous reset between edges with busy=F0, then restart from empty.
  task automatic test_async_reset();
    for (int i = 4; i < 8; i++) begin
      iss_en = 1'b1; iss_addr = 3'(i);
      tick();
    end
    iss_en = 1'b0;
    vectors++; if (busy !== 8'hF0 || busy_cnt !== 4'd4) begin miscompares++; $display("[TB] FAIL pre_reset_state: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'hF0, 4); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 8'h00 || busy_cnt !== 4'd0 || wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset: got %h/%0d/%b expected %h/%0d/%b", busy, busy_cnt, wb_err, 8'h00, 0, 1'b0); end
    iss_en = 1'b1; iss_addr = 3'd2;
    tick();
    vectors++; if (busy !== 8'h00 || iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL held_reset: got %h/%b expected %h/%b", busy, iss_ready, 8'h00, 1'b1); end
    #2 rst_n = 1'b1;
    tick();
    vectors++; if (busy !== 8'h04 || busy_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL post_reset_issue: got %h/%0d expected %h/%0d", busy, busy_cnt, 8'h04, 1); end
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_issue_hold();
    test_same_index();
    test_bypass();
    test_zero_reg();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
